commit_pair_aligner: RTL and testbench
======================================

// Module: commit_pair_aligner
// PURPOSE
// Receiving end of the two-copy commit-observation streams: buffers per-copy commit observations
// in two FIFOs and releases them in lockstep pairs to the contract comparator, replacing
// clock-stall alignment for skews up to DEPTH commits. Clock-gating requests go back to a copy
// only when its FIFO nears full. Sits between each BoomTile ROB commit port and the shadow checker.
// PARAMETERS
// OBS_W     64  width of one commit observation (rs1/rs2/addr digest)
// DEPTH     8   entries per copy FIFO, power of two, >=4
// CNT_W     32  width of matched-pair counter
// PORTS
// clk            in   1          system clock
// rst            in   1          synchronous, active-high reset
// commit_1_i     in   1          copy1 ROB commit valid (slot 0)
// obs_1_i        in   OBS_W      copy1 observation for that commit
// commit_2_i     in   1          copy2 ROB commit valid
// obs_2_i        in   OBS_W      copy2 observation
// stall_1_o      out  1          clock-gate request for copy1
// stall_2_o      out  1          clock-gate request for copy2
// pair_valid_o   out  1          aligned pair available
// pair_ready_i   in   1          comparator accepts pair
// pair_obs_1_o   out  OBS_W      copy1 half of pair
// pair_obs_2_o   out  OBS_W      copy2 half of pair
// mismatch_o     out  1          sticky: some released pair differed
// mismatch_idx_o out  CNT_W      pair index of first mismatch
// pair_cnt_o     out  CNT_W      pairs released so far
// overflow_o     out  1          sticky: push into full FIFO (dropped)
// drain_i        in   1          end of run: no further commits expected
// unpaired_o     out  1          drain_i seen with leftover unmatched entries
// BEHAVIOUR
// - Reset: all outputs 0, FIFOs empty, pointers/counters 0; reset mid-run discards all entries.
// - Push x: commit_x_i && !full_x -> write obs_x_i at wptr_x. commit_x_i && full_x -> drop, overflow_o<=1.
// - Occupancy occ_x in [0,DEPTH]; push+pop same cycle leaves occ_x unchanged; pointers wrap mod DEPTH.
// - stall_x_o registered: next-cycle value = (occ_x after this cycle's update >= DEPTH-1). Allows the
//   one in-flight commit arriving while the gate takes effect; full only reached, never exceeded.
// - Output stage is one register. Load when both FIFOs non-empty and (!pair_valid_o || pair_ready_i);
//   pops both heads same cycle. Latency: commit of the later copy -> pair_valid_o next cycle
//   (write-through not allowed; empty FIFO needs one cycle).
// - pair_valid_o held with stable data until pair_ready_i; deasserts after accept if nothing to load.
// - On each load: pair_cnt_o++ (wraps at 2^CNT_W); if heads differ and !mismatch_o:
//   mismatch_o<=1, mismatch_idx_o<=pre-increment pair_cnt_o. Later mismatches do not update idx.
// - Simultaneous commit on both copies with both FIFOs empty: both pushed, pair out next cycle.
// - unpaired_o (sticky): set in a cycle with drain_i && occ_1 != occ_2 && no push pending; equal
//   occupancies drain normally and never set it.
// - stall_x_o never both 1 by construction only if DEPTH>=4 and pops proceed; if both FIFOs full and
//   pair_ready_i stuck low both stalls assert (allowed, comparator backpressure).
// STRUCTURE
// - shadow_pkg: typedef logic [OBS_W-1:0] obs_t; localparam DEPTH default; occupancy width $clog2(DEPTH)+1.
// - Sub-module obs_fifo (sync FIFO, push/pop/full/empty/occ), instantiated twice; aligner, counters,
//   compare and stall regs in top level.
// TESTING
// - Lockstep: both copies commit obs 0x10..0x17 same cycles, ready=1 -> 8 pairs, pair_cnt=8, mismatch=0, no stall.
// - Skew: copy1 commits 7 obs, copy2 idle -> stall_1_o=1 after occ_1 reaches 7; copy2 then commits 7 -> 7 matched pairs, stall_1_o clears.
// - Mismatch: pair 3 has obs_2=0xDEAD vs obs_1=0xBEEF, pair 5 also differs -> mismatch_o=1, mismatch_idx_o=3.
// - Backpressure: pair_ready_i=0 for 20 cycles, both copies commit 8 -> output held stable, both stalls 1, no overflow.
// - Overflow: ignore stall_1_o, push 9 into empty copy1 FIFO with ready=0 -> overflow_o=1, 8 entries retained.
// - Drain/reset: copy1 3 commits, copy2 2, drain_i=1 -> unpaired_o=1; then rst mid-run -> all outputs 0, FIFOs empty.

Source files
------------

// File: rtl/commit_pair_aligner_pkg.sv
// Shared types and sizing helpers for the two-copy commit-pair aligner.
package commit_pair_aligner_pkg;

  localparam int OBS_W_DEF = 64;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 32;

  typedef logic [OBS_W_DEF-1:0] obs_t;

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/commit_pair_aligner_obs_fifo.sv
// Synchronous per-copy observation FIFO; push when full and pop when empty are ignored.
module commit_pair_aligner_obs_fifo
  import commit_pair_aligner_pkg::*;
#(
  parameter int W     = OBS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [occ_width(DEPTH)-1:0]  occ
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [OCC_W-1:0] occ_r;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array, deliberately without reset: pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      occ_r <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign full  = (occ_r == OCC_W'(DEPTH));
  assign empty = (occ_r == '0);
  assign dout  = mem[rptr];
  assign occ   = occ_r;

endmodule

// File: rtl/commit_pair_aligner.sv
// Buffers two copies' commit observations and releases them as lockstep pairs,
// with registered near-full stall requests, mismatch tracking and drain checks.
module commit_pair_aligner
  import commit_pair_aligner_pkg::*;
#(
  parameter int OBS_W = OBS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_1_i,
  input  logic [OBS_W-1:0] obs_1_i,
  input  logic             commit_2_i,
  input  logic [OBS_W-1:0] obs_2_i,
  output logic             stall_1_o,
  output logic             stall_2_o,
  output logic             pair_valid_o,
  input  logic             pair_ready_i,
  output logic [OBS_W-1:0] pair_obs_1_o,
  output logic [OBS_W-1:0] pair_obs_2_o,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] mismatch_idx_o,
  output logic [CNT_W-1:0] pair_cnt_o,
  output logic             overflow_o,
  input  logic             drain_i,
  output logic             unpaired_o
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [OBS_W-1:0] head_1;
  logic [OBS_W-1:0] head_2;
  logic             full_1;
  logic             full_2;
  logic             empty_1;
  logic             empty_2;
  logic [OCC_W-1:0] occ_1;
  logic [OCC_W-1:0] occ_2;
  logic [OCC_W-1:0] occ_nxt_1;
  logic [OCC_W-1:0] occ_nxt_2;
  logic             push_1;
  logic             push_2;
  logic             load;
  logic             drop;
  logic             unpaired_hit;

  assign push_1 = commit_1_i && !full_1;
  assign push_2 = commit_2_i && !full_2;
  assign drop   = (commit_1_i && full_1) || (commit_2_i && full_2);
  assign load   = !empty_1 && !empty_2 && (!pair_valid_o || pair_ready_i);
  assign unpaired_hit = drain_i && (occ_1 != occ_2) && !commit_1_i && !commit_2_i;

  commit_pair_aligner_obs_fifo #(.W(OBS_W), .DEPTH(DEPTH)) u_fifo_1 (
    .clk   (clk),
    .rst   (rst),
    .push  (commit_1_i),
    .din   (obs_1_i),
    .pop   (load),
    .dout  (head_1),
    .full  (full_1),
    .empty (empty_1),
    .occ   (occ_1)
  );

  commit_pair_aligner_obs_fifo #(.W(OBS_W), .DEPTH(DEPTH)) u_fifo_2 (
    .clk   (clk),
    .rst   (rst),
    .push  (commit_2_i),
    .din   (obs_2_i),
    .pop   (load),
    .dout  (head_2),
    .full  (full_2),
    .empty (empty_2),
    .occ   (occ_2)
  );

  // Post-update occupancy of each FIFO; it feeds the stall registers.
  always_comb begin
    occ_nxt_1 = occ_1;
    occ_nxt_2 = occ_2;
    case ({push_1, load})
      2'b10:   occ_nxt_1 = occ_1 + OCC_W'(1);
      2'b01:   occ_nxt_1 = occ_1 - OCC_W'(1);
      default: occ_nxt_1 = occ_1;
    endcase
    case ({push_2, load})
      2'b10:   occ_nxt_2 = occ_2 + OCC_W'(1);
      2'b01:   occ_nxt_2 = occ_2 - OCC_W'(1);
      default: occ_nxt_2 = occ_2;
    endcase
  end

  // Stall at DEPTH-1 leaves room for the one commit already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_1_o  <= 1'b0;
      stall_2_o  <= 1'b0;
      overflow_o <= 1'b0;
      unpaired_o <= 1'b0;
    end else begin
      stall_1_o  <= (occ_nxt_1 >= OCC_W'(DEPTH - 1));
      stall_2_o  <= (occ_nxt_2 >= OCC_W'(DEPTH - 1));
      overflow_o <= overflow_o | drop;
      unpaired_o <= unpaired_o | unpaired_hit;
    end
  end

  // Output register: load a pair, hold under backpressure, clear after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_valid_o   <= 1'b0;
      pair_obs_1_o   <= '0;
      pair_obs_2_o   <= '0;
      pair_cnt_o     <= '0;
      mismatch_o     <= 1'b0;
      mismatch_idx_o <= '0;
    end else if (load) begin
      pair_valid_o <= 1'b1;
      pair_obs_1_o <= head_1;
      pair_obs_2_o <= head_2;
      pair_cnt_o   <= pair_cnt_o + CNT_W'(1);
      if ((head_1 != head_2) && !mismatch_o) begin
        mismatch_o     <= 1'b1;
        mismatch_idx_o <= pair_cnt_o;
      end
    end else if (pair_ready_i) begin
      pair_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_commit_pair_aligner.sv
// Scoreboard bench: per-copy expected observations are queued when driven and
// compared when the aligner hands a pair to the comparator.
module tb_commit_pair_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_1_i, commit_2_i;
  logic [63:0] obs_1_i, obs_2_i;
  logic        stall_1_o, stall_2_o;
  logic        pair_valid_o, pair_ready_i;
  logic [63:0] pair_obs_1_o, pair_obs_2_o;
  logic        mismatch_o;
  logic [31:0] mismatch_idx_o, pair_cnt_o;
  logic        overflow_o, drain_i, unpaired_o;

  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] exp1[$];
  logic [63:0] exp2[$];

  always #5 clk = ~clk;

  commit_pair_aligner dut (
    .clk            (clk),
    .rst            (rst),
    .commit_1_i     (commit_1_i),
    .obs_1_i        (obs_1_i),
    .commit_2_i     (commit_2_i),
    .obs_2_i        (obs_2_i),
    .stall_1_o      (stall_1_o),
    .stall_2_o      (stall_2_o),
    .pair_valid_o   (pair_valid_o),
    .pair_ready_i   (pair_ready_i),
    .pair_obs_1_o   (pair_obs_1_o),
    .pair_obs_2_o   (pair_obs_2_o),
    .mismatch_o     (mismatch_o),
    .mismatch_idx_o (mismatch_idx_o),
    .pair_cnt_o     (pair_cnt_o),
    .overflow_o     (overflow_o),
    .drain_i        (drain_i),
    .unpaired_o     (unpaired_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Drive one cycle of commits; keep1=0 marks a copy1 commit the DUT must drop.
  task automatic step(input logic c1, input logic [63:0] o1,
                      input logic c2, input logic [63:0] o2,
                      input logic keep1 = 1'b1);
    commit_1_i = c1; obs_1_i = o1;
    commit_2_i = c2; obs_2_i = o2;
    if (c1 && keep1) exp1.push_back(o1);
    if (c2) exp2.push_back(o2);
    @(posedge clk); #1;
    commit_1_i = 1'b0;
    commit_2_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    commit_1_i = 1'b0; commit_2_i = 1'b0;
    obs_1_i = 64'h0; obs_2_i = 64'h0;
    drain_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp1.delete();
    exp2.delete();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_stall_1"},    stall_1_o, 64'd0);
    chk({tag, "_stall_2"},    stall_2_o, 64'd0);
    chk({tag, "_pair_valid"}, pair_valid_o, 64'd0);
    chk({tag, "_pair_obs_1"}, pair_obs_1_o, 64'd0);
    chk({tag, "_pair_obs_2"}, pair_obs_2_o, 64'd0);
    chk({tag, "_mismatch"},   mismatch_o, 64'd0);
    chk({tag, "_mis_idx"},    mismatch_idx_o, 64'd0);
    chk({tag, "_pair_cnt"},   pair_cnt_o, 64'd0);
    chk({tag, "_overflow"},   overflow_o, 64'd0);
    chk({tag, "_unpaired"},   unpaired_o, 64'd0);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_left_1"}, 64'(exp1.size()), 64'd0);
    chk({tag, "_left_2"}, 64'(exp2.size()), 64'd0);
  endtask

  // Scoreboard: every accepted pair must match the oldest queued observations.
  always @(negedge clk) begin
    if (!rst && pair_valid_o && pair_ready_i) begin
      if (exp1.size() == 0 || exp2.size() == 0) begin
        chk("pair_unexpected", 64'd1, 64'd0);
      end else begin
        chk("pair_obs_1", pair_obs_1_o, exp1.pop_front());
        chk("pair_obs_2", pair_obs_2_o, exp2.pop_front());
      end
    end
  end

  initial begin
    pair_ready_i = 1'b0;
    do_reset();
    check_cleared("reset");

    // Lockstep commits, ready held high.
    pair_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 64'h10 + 64'(i), 1'b1, 64'h10 + 64'(i));
      if (i == 0) chk("lat_first", pair_valid_o, 64'd0);
      if (i == 1) chk("lat_next", pair_valid_o, 64'd1);
      chk("lock_stall_1", stall_1_o, 64'd0);
      chk("lock_stall_2", stall_2_o, 64'd0);
    end
    idle(3);
    chk("lock_cnt", pair_cnt_o, 64'd8);
    chk("lock_mismatch", mismatch_o, 64'd0);
    chk("lock_valid_idle", pair_valid_o, 64'd0);
    drain_i = 1'b1;
    idle(3);
    chk("lock_drain_unpaired", unpaired_o, 64'd0);
    drain_i = 1'b0;
    check_drained("lock");

    // Skew: copy1 runs ahead by 7 commits.
    do_reset();
    pair_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 64'h20 + 64'(i), 1'b0, 64'h0);
      if (i == 5) chk("skew_stall_occ6", stall_1_o, 64'd0);
      if (i == 6) chk("skew_stall_occ7", stall_1_o, 64'd1);
    end
    chk("skew_no_pair", pair_valid_o, 64'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 64'h0, 1'b1, 64'h20 + 64'(i));
    idle(4);
    chk("skew_stall_clear", stall_1_o, 64'd0);
    chk("skew_stall_2", stall_2_o, 64'd0);
    chk("skew_cnt", pair_cnt_o, 64'd7);
    check_drained("skew");

    // Mismatch at pair 3 and again at pair 5.
    do_reset();
    pair_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3)      step(1'b1, 64'hBEEF, 1'b1, 64'hDEAD);
      else if (i == 5) step(1'b1, 64'h55, 1'b1, 64'h66);
      else             step(1'b1, 64'h30 + 64'(i), 1'b1, 64'h30 + 64'(i));
    end
    idle(3);
    chk("mis_flag", mismatch_o, 64'd1);
    chk("mis_idx", mismatch_idx_o, 64'd3);
    chk("mis_cnt", pair_cnt_o, 64'd7);
    check_drained("mis");

    // Backpressure: comparator stalls while both copies commit 8.
    do_reset();
    pair_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 64'h40 + 64'(i), 1'b1, 64'h40 + 64'(i));
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", pair_valid_o, 64'd1);
      chk("bp_hold_1", pair_obs_1_o, 64'h40);
      chk("bp_hold_2", pair_obs_2_o, 64'h40);
      idle(1);
    end
    chk("bp_stall_1", stall_1_o, 64'd1);
    chk("bp_stall_2", stall_2_o, 64'd1);
    chk("bp_overflow", overflow_o, 64'd0);
    chk("bp_cnt_held", pair_cnt_o, 64'd1);
    pair_ready_i = 1'b1;
    idle(12);
    chk("bp_cnt", pair_cnt_o, 64'd8);
    chk("bp_stall_1_clear", stall_1_o, 64'd0);
    chk("bp_stall_2_clear", stall_2_o, 64'd0);
    check_drained("bp");

    // Overflow: 9 pushes into copy1, the last one dropped.
    do_reset();
    pair_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 64'h50 + 64'(i), 1'b0, 64'h0, (i < 8));
      if (i == 7) chk("ovf_before", overflow_o, 64'd0);
    end
    chk("ovf_flag", overflow_o, 64'd1);
    chk("ovf_stall_1", stall_1_o, 64'd1);
    pair_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 64'h0, 1'b1, 64'h50 + 64'(i));
    idle(6);
    chk("ovf_cnt", pair_cnt_o, 64'd8);
    chk("ovf_mismatch", mismatch_o, 64'd0);
    check_drained("ovf");

    // Drain with unequal leftovers, then reset mid-run.
    do_reset();
    pair_ready_i = 1'b1;
    step(1'b1, 64'h60, 1'b1, 64'h60);
    step(1'b1, 64'h61, 1'b1, 64'h61);
    step(1'b1, 64'h62, 1'b0, 64'h0);
    idle(3);
    chk("drain_pre", unpaired_o, 64'd0);
    chk("drain_cnt", pair_cnt_o, 64'd2);
    drain_i = 1'b1;
    idle(2);
    chk("drain_unpaired", unpaired_o, 64'd1);
    do_reset();
    check_cleared("midrst");
    step(1'b0, 64'h0, 1'b1, 64'h70);
    idle(3);
    chk("midrst_fifo1_empty", pair_valid_o, 64'd0);
    chk("midrst_cnt", pair_cnt_o, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
